// File: rtl/window_minmax_tracker_pkg.sv
// Shared types and constants for the windowed min/max tracker.
// The index width is derived from the window length by idx_width().
package window_minmax_tracker_pkg;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_e;

  localparam int unsigned DefaultWidth  = 8;
  localparam int unsigned DefaultWindow = 16;

  // Keep at least one bit so degenerate parameterisations still elaborate.
  function automatic int unsigned idx_width(input int unsigned window);
    return (window < 2) ? 1 : $clog2(window);
  endfunction

endpackage

// File: rtl/window_minmax_tracker_cmp_unit.sv
// Unsigned magnitude comparator: one-hot gt/eq/lt of a_i relative to b_i.
// Purely combinational; the tracker uses one instance per reference register.
module window_minmax_tracker_cmp_unit
  import window_minmax_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  always_comb begin
    gt_o = 1'b0;
    eq_o = 1'b0;
    lt_o = 1'b0;
    if (a_i > b_i) begin
      gt_o = 1'b1;
    end else if (a_i == b_i) begin
      eq_o = 1'b1;
    end else begin
      lt_o = 1'b1;
    end
  end

endmodule

// File: rtl/window_minmax_tracker.sv
// Streaming window min/max tracker: accumulates WINDOW samples, then holds the
// max/min, their first-occurrence indices and an all-equal flag until consumed.
module window_minmax_tracker
  import window_minmax_tracker_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned WINDOW = DefaultWindow,
  // Derived from WINDOW; not meant to be overridden.
  parameter int unsigned IDX_W  = idx_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_max_o,
  output logic [WIDTH-1:0] out_min_o,
  output logic [IDX_W-1:0] out_max_idx_o,
  output logic [IDX_W-1:0] out_min_idx_o,
  output logic             out_eq_all_o
);

  localparam logic [IDX_W-1:0] LastCnt = IDX_W'(WINDOW - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;
  logic             eq_q, eq_d;

  logic [WIDTH-1:0] res_max_q;
  logic [WIDTH-1:0] res_min_q;
  logic [IDX_W-1:0] res_max_idx_q;
  logic [IDX_W-1:0] res_min_idx_q;
  logic             res_eq_q;

  logic acc_load;
  logic res_load;

  logic gt_max, eq_max, lt_max;
  logic gt_min, eq_min, lt_min;
  logic unused_cmp;

  window_minmax_tracker_cmp_unit #(
    .WIDTH (WIDTH)
  ) u_cmp_max (
    .a_i  (in_data_i),
    .b_i  (max_q),
    .gt_o (gt_max),
    .eq_o (eq_max),
    .lt_o (lt_max)
  );

  window_minmax_tracker_cmp_unit #(
    .WIDTH (WIDTH)
  ) u_cmp_min (
    .a_i  (in_data_i),
    .b_i  (min_q),
    .gt_o (gt_min),
    .eq_o (eq_min),
    .lt_o (lt_min)
  );

  assign unused_cmp = ^{lt_max, gt_min};

  // Candidate accumulator values if the current sample is accepted.
  always_comb begin
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    eq_d      = eq_q;
    if (count_q == '0) begin
      max_d     = in_data_i;
      min_d     = in_data_i;
      max_idx_d = '0;
      min_idx_d = '0;
      eq_d      = 1'b1;
    end else begin
      if (gt_max) begin
        max_d     = in_data_i;
        max_idx_d = count_q;
      end
      if (lt_min) begin
        min_d     = in_data_i;
        min_idx_d = count_q;
      end
      // While eq_q holds, max == min, so requiring both equalities changes nothing.
      eq_d = eq_q & eq_max & eq_min;
    end
  end

  // Handshake and window sequencing; clear overrides every transfer.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_load = 1'b0;
    res_load = 1'b0;
    if (clear_i) begin
      state_d = ST_ACCUM;
      count_d = '0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (in_valid_i) begin
            acc_load = 1'b1;
            if (count_q == LastCnt) begin
              count_d  = '0;
              state_d  = ST_REPORT;
              res_load = 1'b1;
            end else begin
              count_d = count_q + IDX_W'(1);
            end
          end
        end
        ST_REPORT: begin
          if (out_ready_i) begin
            state_d = ST_ACCUM;
          end
        end
        default: begin
          state_d = ST_ACCUM;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      eq_q      <= 1'b0;
    end else if (acc_load) begin
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      eq_q      <= eq_d;
    end
  end

  // Result registers capture the window including its final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_max_q     <= '0;
      res_min_q     <= '0;
      res_max_idx_q <= '0;
      res_min_idx_q <= '0;
      res_eq_q      <= 1'b0;
    end else if (res_load) begin
      res_max_q     <= max_d;
      res_min_q     <= min_d;
      res_max_idx_q <= max_idx_d;
      res_min_idx_q <= min_idx_d;
      res_eq_q      <= eq_d;
    end
  end

  assign in_ready_o    = (state_q == ST_ACCUM);
  assign out_valid_o   = (state_q == ST_REPORT);
  assign out_max_o     = res_max_q;
  assign out_min_o     = res_min_q;
  assign out_max_idx_o = res_max_idx_q;
  assign out_min_idx_o = res_min_idx_q;
  assign out_eq_all_o  = res_eq_q;

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Directed bench for window_minmax_tracker: a WINDOW=4 instance driven from a
// vector table, a WINDOW=5 instance for wrap checks, and an async reset sequence.
module tb_window_minmax_tracker;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WINDOW = 4 instance
  logic       c4_clear, c4_in_valid, c4_in_ready, c4_out_valid, c4_out_ready, c4_eq;
  logic [7:0] c4_in_data, c4_max, c4_min;
  logic [1:0] c4_max_idx, c4_min_idx;

  // WINDOW = 5 instance
  logic       c5_clear, c5_in_valid, c5_in_ready, c5_out_valid, c5_out_ready, c5_eq;
  logic [7:0] c5_in_data, c5_max, c5_min;
  logic [2:0] c5_max_idx, c5_min_idx;

  window_minmax_tracker #(.WIDTH(8), .WINDOW(4)) u_dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (c4_clear),
    .in_valid_i    (c4_in_valid),
    .in_ready_o    (c4_in_ready),
    .in_data_i     (c4_in_data),
    .out_valid_o   (c4_out_valid),
    .out_ready_i   (c4_out_ready),
    .out_max_o     (c4_max),
    .out_min_o     (c4_min),
    .out_max_idx_o (c4_max_idx),
    .out_min_idx_o (c4_min_idx),
    .out_eq_all_o  (c4_eq)
  );

  window_minmax_tracker #(.WIDTH(8), .WINDOW(5)) u_dut5 (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (c5_clear),
    .in_valid_i    (c5_in_valid),
    .in_ready_o    (c5_in_ready),
    .in_data_i     (c5_in_data),
    .out_valid_o   (c5_out_valid),
    .out_ready_i   (c5_out_ready),
    .out_max_o     (c5_max),
    .out_min_o     (c5_min),
    .out_max_idx_o (c5_max_idx),
    .out_min_idx_o (c5_min_idx),
    .out_eq_all_o  (c5_eq)
  );

  typedef struct {
    logic       clr;
    logic       vld;
    logic [7:0] dat;
    logic       ordy;
    logic       e_vld;
    logic       e_rdy;
    logic       chk;
    logic [7:0] e_max;
    logic [1:0] e_maxi;
    logic [7:0] e_min;
    logic [1:0] e_mini;
    logic       e_eq;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Handshake-only vector: no result check.
  function automatic vec_t va(input logic clr, input logic vld, input logic [7:0] dat,
                              input logic ordy, input logic e_vld, input logic e_rdy);
    vec_t v;
    v.clr = clr; v.vld = vld; v.dat = dat; v.ordy = ordy;
    v.e_vld = e_vld; v.e_rdy = e_rdy; v.chk = 1'b0;
    v.e_max = '0; v.e_maxi = '0; v.e_min = '0; v.e_mini = '0; v.e_eq = 1'b0;
    return v;
  endfunction

  // Vector that expects REPORT with the given result afterwards.
  function automatic vec_t vr(input logic vld, input logic [7:0] dat, input logic ordy,
                              input logic [7:0] mx, input logic [1:0] mxi,
                              input logic [7:0] mn, input logic [1:0] mni, input logic eq);
    vec_t v;
    v.clr = 1'b0; v.vld = vld; v.dat = dat; v.ordy = ordy;
    v.e_vld = 1'b1; v.e_rdy = 1'b0; v.chk = 1'b1;
    v.e_max = mx; v.e_maxi = mxi; v.e_min = mn; v.e_mini = mni; v.e_eq = eq;
    return v;
  endfunction

  function automatic vec_t acc(input logic [7:0] dat);
    return va(1'b0, 1'b1, dat, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic drive4(input logic clr, input logic vld, input logic [7:0] dat,
                        input logic ordy);
    c4_clear = clr; c4_in_valid = vld; c4_in_data = dat; c4_out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4_res(input string nm, input int mx, input int mxi, input int mn,
                          input int mni, input int eq);
    chk({nm, ".max"}, c4_max, mx);
    chk({nm, ".max_idx"}, c4_max_idx, mxi);
    chk({nm, ".min"}, c4_min, mn);
    chk({nm, ".min_idx"}, c4_min_idx, mni);
    chk({nm, ".eq_all"}, c4_eq, eq);
  endtask

  initial begin
    int exp5_max[3]  = '{5, 10, 15};
    int exp5_min[3]  = '{1, 6, 11};
    int s;
    int accepted;
    int results;
    logic was_rdy;

    c4_clear = 1'b0; c4_in_valid = 1'b0; c4_in_data = '0; c4_out_ready = 1'b0;
    c5_clear = 1'b0; c5_in_valid = 1'b0; c5_in_data = '0; c5_out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset.out_valid", c4_out_valid, 0);
    chk("reset.in_ready", c4_in_ready, 1);
    chk4_res("reset", 0, 0, 0, 0, 0);
    chk("reset5.out_valid", c5_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back window, then backpressure with in_valid held high.
    vecs.push_back(acc(8'd10));
    vecs.push_back(acc(8'd200));
    vecs.push_back(acc(8'd5));
    vecs.push_back(vr(1'b1, 8'd200, 1'b0, 8'd200, 2'd1, 8'd5, 2'd2, 1'b0));
    for (int i = 0; i < 5; i++) vecs.push_back(vr(1'b1, 8'd99, 1'b0, 8'd200, 2'd1, 8'd5, 2'd2, 1'b0));
    vecs.push_back(va(1'b0, 1'b1, 8'd77, 1'b1, 1'b0, 1'b1));
    // All-equal window, then extremes 0x00 / 0xFF.
    for (int i = 0; i < 3; i++) vecs.push_back(acc(8'h7F));
    vecs.push_back(vr(1'b1, 8'h7F, 1'b0, 8'h7F, 2'd0, 8'h7F, 2'd0, 1'b1));
    vecs.push_back(va(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(acc(8'h00));
    vecs.push_back(acc(8'hFF));
    vecs.push_back(acc(8'hFF));
    vecs.push_back(vr(1'b1, 8'h00, 1'b0, 8'hFF, 2'd1, 8'h00, 2'd0, 1'b0));
    vecs.push_back(va(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
    // Clear mid-window discards the accept in the same cycle.
    vecs.push_back(acc(8'd50));
    vecs.push_back(acc(8'd1));
    vecs.push_back(va(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(acc(8'd9));
    vecs.push_back(acc(8'd3));
    vecs.push_back(acc(8'd3));
    vecs.push_back(vr(1'b1, 8'd8, 1'b0, 8'd9, 2'd0, 8'd3, 2'd1, 1'b0));
    // Clear in REPORT drops the result without a transfer.
    vecs.push_back(va(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));
    // All-zero window.
    for (int i = 0; i < 3; i++) vecs.push_back(acc(8'd0));
    vecs.push_back(vr(1'b1, 8'd0, 1'b0, 8'd0, 2'd0, 8'd0, 2'd0, 1'b1));
    vecs.push_back(va(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive4(vecs[i].clr, vecs[i].vld, vecs[i].dat, vecs[i].ordy);
      chk($sformatf("vec%0d.out_valid", i), c4_out_valid, vecs[i].e_vld);
      chk($sformatf("vec%0d.in_ready", i), c4_in_ready, vecs[i].e_rdy);
      if (vecs[i].chk) begin
        chk4_res($sformatf("vec%0d", i), vecs[i].e_max, vecs[i].e_maxi, vecs[i].e_min,
                 vecs[i].e_mini, vecs[i].e_eq);
      end
    end
    drive4(1'b0, 1'b0, 8'd0, 1'b0);

    // WINDOW=5: samples 1..15 with the consumer always ready.
    s = 1; accepted = 0; results = 0;
    c5_in_valid = 1'b1; c5_out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && accepted < 15; cyc++) begin
      c5_in_data = 8'(s);
      was_rdy = c5_in_ready;
      @(posedge clk);
      #1;
      if (was_rdy) begin
        s++;
        accepted++;
      end
      chk($sformatf("w5.cyc%0d.ready_vs_valid", cyc), c5_in_ready, !c5_out_valid);
      if (c5_out_valid) begin
        if (results < 3) begin
          chk($sformatf("w5.res%0d.max", results), c5_max, exp5_max[results]);
          chk($sformatf("w5.res%0d.max_idx", results), c5_max_idx, 4);
          chk($sformatf("w5.res%0d.min", results), c5_min, exp5_min[results]);
          chk($sformatf("w5.res%0d.min_idx", results), c5_min_idx, 0);
          chk($sformatf("w5.res%0d.eq_all", results), c5_eq, 0);
        end
        results++;
      end
    end
    chk("w5.accepted", accepted, 15);
    chk("w5.results", results, 3);
    c5_in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Async reset while holding a result in REPORT.
    drive4(1'b0, 1'b1, 8'd1, 1'b0);
    drive4(1'b0, 1'b1, 8'd2, 1'b0);
    drive4(1'b0, 1'b1, 8'd3, 1'b0);
    drive4(1'b0, 1'b1, 8'd4, 1'b0);
    chk("rst.pre.out_valid", c4_out_valid, 1);
    chk4_res("rst.pre", 4, 3, 1, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst.mid.out_valid", c4_out_valid, 0);
    chk("rst.mid.in_ready", c4_in_ready, 1);
    chk4_res("rst.mid", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive4(1'b0, 1'b0, 8'd0, 1'b1);
    chk("rst.post.out_valid", c4_out_valid, 0);
    chk("rst.post.in_ready", c4_in_ready, 1);
    drive4(1'b0, 1'b1, 8'd4, 1'b0);
    drive4(1'b0, 1'b1, 8'd3, 1'b0);
    drive4(1'b0, 1'b1, 8'd2, 1'b0);
    chk("rst.win.out_valid_early", c4_out_valid, 0);
    drive4(1'b0, 1'b1, 8'd1, 1'b0);
    chk("rst.win.out_valid", c4_out_valid, 1);
    chk4_res("rst.win", 4, 0, 1, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/window_minmax_tracker.md
Name: window_minmax_tracker

Overview:
- Streaming block that consumes unsigned samples over a valid/ready handshake.
- Tracks the running maximum and minimum over a fixed window of WINDOW samples, plus the index of each and an all-equal flag.
- Presents the result on a registered valid/ready output port.
- Sits downstream of the magnitude-comparison logic and reuses its greater/equal/less decision as the core of the update path.

Parameters:
- WIDTH, 8, sample width in bits; samples are unsigned.
- WINDOW, 16, samples per window; legal range 2..256.
- IDX_W, $clog2(WINDOW), width of the index and count fields; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous window abort, active-high.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  WIDTH  sample.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out_max  out  WIDTH  largest sample in the window.
- out_min  out  WIDTH  smallest sample in the window.
- out_max_idx  out  IDX_W  position (0-based) of the first occurrence of the max.
- out_min_idx  out  IDX_W  position of the first occurrence of the min.
- out_eq_all  out  1  all WINDOW samples were identical.

Behaviour:
- Reset (rst_n low, asynchronous): state ACCUM, count 0, out_valid 0, all result outputs 0, internal max/min registers 0.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - REPORT: in_ready = 0, out_valid = 1.
  - in_ready and out_valid are decoded from state only, never from in_valid or out_ready.
- Accept: in_valid & in_ready on a rising edge.
- First accept of a window (count == 0):
  - max = min = in_data.
  - max_idx = min_idx = 0.
  - eq_all = 1.
- Later accepts, compared against the current registers:
  - Strictly greater: update max and max_idx.
  - Strictly less: update min and min_idx.
  - Equal: no update, so the first occurrence wins.
  - eq_all &= (in_data == max).
- count increments on every accept. On the accept with count == WINDOW-1:
  - count wraps to 0.
  - State goes to REPORT.
  - Outputs are loaded with the final values, including that last sample.
- Latency: out_valid rises on the edge that accepts the WINDOW-th sample, i.e. it is visible the following cycle.
- REPORT:
  - Outputs are held stable while out_valid & !out_ready, regardless of in_valid.
  - On out_valid & out_ready: return to ACCUM next cycle; in_ready = 1 that cycle. No bubble beyond the one state change.
- clear:
  - Takes priority over every handshake that cycle.
  - Any accept or output transfer in that cycle is discarded.
  - Next state ACCUM, count 0, out_valid 0.
  - Result outputs keep their last values; they are undefined to the consumer while out_valid = 0.
- Boundaries:
  - Samples 0 and 2^WIDTH-1 are legal and compared unsigned.
  - A window of all 0 gives max = min = 0 and eq_all = 1.
  - Non-power-of-two WINDOW: count wraps at WINDOW-1, not at 2^IDX_W-1.
- rst_n asserted mid-window or mid-REPORT: partial window is lost, outputs return to reset values immediately, and no stale out_valid appears after release.
- No combinational path from in_data or out_ready to any output.

Decomposition:
- Shared package:
  - state enum {ST_ACCUM, ST_REPORT}.
  - Default WIDTH and WINDOW constants.
  - A function computing IDX_W.
- Sub-module cmp_unit (combinational, parameterised by WIDTH) returns gt/eq/lt for (in_data, ref). Two instances: ref = max register, ref = min register.
- FSM, counter and result registers live in the top module.

Test Plan:
- WINDOW=4, samples 10, 200, 5, 200 back-to-back -> out_max=200, out_max_idx=1, out_min=5, out_min_idx=2, out_eq_all=0, out_valid high the cycle after the 4th accept.
- WINDOW=4, samples 0x7F x4 -> max=min=0x7F, both idx=0, eq_all=1. Then samples 0x00, 0xFF, 0xFF, 0x00 -> max=0xFF idx=1, min=0x00 idx=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid stays 1, in_ready stays 0, outputs unchanged. Raise out_ready -> in_ready=1 on the next cycle.
- clear after 2 of 4 samples, then feed 9, 3, 3, 8 -> result max=9 idx0, min=3 idx1; pre-clear samples have no effect.
- WINDOW=5 (non-power-of-two), feed 12 samples 1..12 -> two results, (max=5 idx4, min=1 idx0) and (max=10 idx4, min=6 idx0), count resumes at 0 for the third window.
- rst_n pulsed low asynchronously mid-clock while in REPORT -> out_valid=0 and outputs=0 at once. After release, in_ready=1 and the next full window reports correctly.
